// File: rtl/rx_adc_capture_sched.sv
// ---------------------------------------------------------------------------
// rx_adc_capture_sched
//   Captures frames of 14 ADC lane words into a write-only capture memory.
//   On each frame_valid pulse received while ARMED, all lane words and the
//   lane-enable mask are copied into shadow registers. The enabled lanes are
//   then written in ascending lane order to consecutive memory addresses,
//   with mem_ready back-pressure. A frame that arrives while the previous
//   frame is still being written is dropped, and the overflow flag is set.
//
// Ports
//   rx_adc_mem_clk       clock; all logic uses the rising edge
//   RX_ADC_RST_ACTHIGH   synchronous active-high reset
//   lane_data_flat       14 lane words; lane k at [k*DATA_W +: DATA_W]
//   frame_valid          one-cycle frame strobe
//   lane_en              lane-select mask, bit k enables lane k
//   arm / abort          start / stop capture pulses (abort wins)
//   frame_limit          frames per capture, 0 = continuous
//   mem_ready            memory accepts the write this cycle
//   mem_we/addr/wdata    memory write port
//   busy / done          status (ARMED|WRITE / DONE)
//   overflow             sticky dropped-frame flag
//   frames_captured      completed-frame count, saturating
// ---------------------------------------------------------------------------
module rx_adc_capture_sched #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic                 rx_adc_mem_clk,
  input  logic                 RX_ADC_RST_ACTHIGH,
  input  logic [14*DATA_W-1:0] lane_data_flat,
  input  logic                 frame_valid,
  input  logic [13:0]          lane_en,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [15:0]          frame_limit,
  input  logic                 mem_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [15:0]          frames_captured
);

  localparam int NLANES = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          lane_q, lane_d;
  logic [13:0]         shadow_en_q, shadow_en_d;
  logic [DATA_W-1:0]   shadow_q [NLANES];
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         frames_q, frames_d;
  logic                ovf_q, ovf_d;
  logic                latch_s;
  logic [4:0]          first_s;
  logic [4:0]          next_s;
  logic [15:0]         frames_inc_s;

  // Lowest set mask bit at or above 'from'; bit 4 of the result flags "found".
  function automatic logic [4:0] lowest_lane_from(input logic [13:0] mask,
                                                  input logic [4:0]  from);
    logic [4:0] r;
    r = 5'd0;
    for (int k = NLANES - 1; k >= 0; k--) begin
      if (mask[k] && (5'(k) >= from)) begin
        r = {1'b1, 4'(k)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign first_s      = lowest_lane_from(lane_en, 5'd0);
  assign next_s       = lowest_lane_from(shadow_en_q, {1'b0, lane_q} + 5'd1);
  assign frames_inc_s = (frames_q == 16'hFFFF) ? frames_q : frames_q + 16'd1;

  // Next-state and datapath update decisions.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    shadow_en_d = shadow_en_q;
    addr_d      = addr_q;
    frames_d    = frames_q;
    ovf_d       = ovf_q;
    latch_s     = 1'b0;
    if (abort) begin
      // Counters, address and overflow deliberately survive an abort.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm && (lane_en != 14'd0)) begin
            state_d  = ST_ARMED;
            addr_d   = '0;
            frames_d = 16'd0;
            ovf_d    = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_ARMED: begin
          // A frame with no enabled lanes has nothing to write and is skipped.
          if (frame_valid && first_s[4]) begin
            state_d     = ST_WRITE;
            latch_s     = 1'b1;
            shadow_en_d = lane_en;
            lane_d      = first_s[3:0];
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_WRITE: begin
          if (frame_valid) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (mem_ready) begin
            addr_d = addr_q + ADDR_W'(1);
            if (next_s[4]) begin
              lane_d = next_s[3:0];
            end else begin
              frames_d = frames_inc_s;
              if ((frame_limit != 16'd0) && (frames_inc_s == frame_limit)) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_ARMED;
              end
            end
          end else begin
            state_d = ST_WRITE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and counter registers.
  always_ff @(posedge rx_adc_mem_clk) begin
    if (RX_ADC_RST_ACTHIGH) begin
      state_q     <= ST_IDLE;
      lane_q      <= 4'd0;
      shadow_en_q <= 14'd0;
      addr_q      <= '0;
      frames_q    <= 16'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      shadow_en_q <= shadow_en_d;
      addr_q      <= addr_d;
      frames_q    <= frames_d;
      ovf_q       <= ovf_d;
    end
  end

  // Shadow copy of all lane words, taken when a frame is accepted.
  always_ff @(posedge rx_adc_mem_clk) begin
    if (RX_ADC_RST_ACTHIGH) begin
      for (int k = 0; k < NLANES; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (latch_s) begin
      for (int k = 0; k < NLANES; k++) begin
        shadow_q[k] <= lane_data_flat[k*DATA_W +: DATA_W];
      end
    end else begin
      for (int k = 0; k < NLANES; k++) begin
        shadow_q[k] <= shadow_q[k];
      end
    end
  end

  // Outputs are decoded directly from registered state.
  assign mem_we          = (state_q == ST_WRITE);
  assign mem_addr        = addr_q;
  assign mem_wdata       = shadow_q[lane_q];
  assign busy            = (state_q == ST_ARMED) || (state_q == ST_WRITE);
  assign done            = (state_q == ST_DONE);
  assign overflow        = ovf_q;
  assign frames_captured = frames_q;

endmodule

// File: tb/tb_rx_adc_capture_sched.sv
module tb_rx_adc_capture_sched;

  localparam int AW = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [14*DW-1:0]  lane_data_flat;
  logic              frame_valid, arm, abort, mem_ready;
  logic [13:0]       lane_en;
  logic [15:0]       frame_limit;
  logic              mem_we, busy, done, overflow;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [15:0]       frames_captured;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];

  rx_adc_capture_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .rx_adc_mem_clk    (clk),
    .RX_ADC_RST_ACTHIGH(rst),
    .lane_data_flat    (lane_data_flat),
    .frame_valid       (frame_valid),
    .lane_en           (lane_en),
    .arm               (arm),
    .abort             (abort),
    .frame_limit       (frame_limit),
    .mem_ready         (mem_ready),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .frames_captured   (frames_captured)
  );

  always #5 clk = ~clk;

  // Record every accepted memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1 && mem_ready === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] lw(input int f, input int k);
    return {8'hC0, 8'(f), 8'h00, 8'(k)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int f);
    for (int k = 0; k < 14; k++) lane_data_flat[k*DW +: DW] = lw(f, k);
  endtask

  task automatic pulse_frame(input int f);
    load_frame(f);
    frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Wait (bounded) until the write burst ends.
  task automatic wait_no_we(input int max_cyc);
    int n;
    n = 0;
    while (mem_we === 1'b1 && n < max_cyc) begin
      cyc();
      n++;
    end
    chk("wait_bound", 64'(n < max_cyc), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},     64'(mem_we), 64'd0);
    chk({tag, "_addr"},   64'(mem_addr), 64'd0);
    chk({tag, "_wdata"},  64'(mem_wdata), 64'd0);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_done"},   64'(done), 64'd0);
    chk({tag, "_ovf"},    64'(overflow), 64'd0);
    chk({tag, "_frames"}, 64'(frames_captured), 64'd0);
  endtask

  initial begin
    rst = 1'b1; lane_data_flat = '0; frame_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    mem_ready = 1'b1; lane_en = 14'd0; frame_limit = 16'd0;
    cyc(); cyc();
    chk_reset_outputs("rst");
    rst = 1'b0;
    cyc();

    // Two frames, lanes 0 and 2, limit 2.
    lane_en = 14'h0005; frame_limit = 16'd2; clear_log();
    do_arm();
    chk("t1_armed_busy", 64'(busy), 64'd1);
    chk("t1_armed_we", 64'(mem_we), 64'd0);
    pulse_frame(1);
    chk("t1_lat_we", 64'(mem_we), 64'd1);
    chk("t1_lat_data", 64'(mem_wdata), 64'(lw(1, 0)));
    cyc();
    chk("t1_w2_addr", 64'(mem_addr), 64'd1);
    cyc();
    chk("t1_back_armed", 64'({busy, mem_we}), 64'b10);
    chk("t1_frames1", 64'(frames_captured), 64'd1);
    for (int i = 0; i < 7; i++) cyc();
    pulse_frame(2);
    cyc(); cyc();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy_off", 64'(busy), 64'd0);
    chk("t1_frames2", 64'(frames_captured), 64'd2);
    chk("t1_nwrites", 64'(wa_q.size()), 64'd4);
    if (wa_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", 64'(wa_q[i]), 64'(i));
        chk("t1_data", 64'(wd_q[i]), 64'(lw(1 + i / 2, (i % 2) * 2)));
      end
    end
    pulse_frame(3);
    cyc(); cyc();
    chk("t1_done_hold", 64'(done), 64'd1);
    chk("t1_done_fv_noovf", 64'(overflow), 64'd0);

    // All 14 lanes, back-pressure on the third write.
    lane_en = 14'h3FFF; frame_limit = 16'd1; clear_log();
    do_arm();
    chk("t2_rearm_clr", 64'(frames_captured), 64'd0);
    pulse_frame(3);
    cyc(); cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_we", 64'(mem_we), 64'd1);
      chk("t2_hold_addr", 64'(mem_addr), 64'd2);
      chk("t2_hold_data", 64'(mem_wdata), 64'(lw(3, 2)));
      cyc();
    end
    mem_ready = 1'b1;
    wait_no_we(40);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_nwrites", 64'(wa_q.size()), 64'd14);
    if (wa_q.size() == 14) begin
      for (int i = 0; i < 14; i++) begin
        chk("t2_addr", 64'(wa_q[i]), 64'(i));
        chk("t2_data", 64'(wd_q[i]), 64'(lw(3, i)));
      end
    end

    // Frame arriving mid-burst is dropped.
    frame_limit = 16'd0; clear_log();
    do_arm();
    pulse_frame(4);
    for (int i = 0; i < 4; i++) cyc();
    pulse_frame(5);
    wait_no_we(40);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_frames", 64'(frames_captured), 64'd1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_nwrites", 64'(wa_q.size()), 64'd14);
    for (int i = 0; i < wa_q.size(); i++) chk("t3_data", 64'(wd_q[i]), 64'(lw(4, i)));
    cyc(); cyc();
    chk("t3_no_second", 64'(mem_we), 64'd0);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t3_abort_idle", 64'(busy), 64'd0);
    chk("t3_abort_ovf_kept", 64'(overflow), 64'd1);
    chk("t3_abort_frames_kept", 64'(frames_captured), 64'd1);

    // Continuous capture with address wrap.
    lane_en = 14'h00FF; frame_limit = 16'd0; clear_log();
    do_arm();
    for (int f = 6; f < 9; f++) begin
      pulse_frame(f);
      for (int i = 0; i < 11; i++) cyc();
      chk("t4_busy", 64'(busy), 64'd1);
      chk("t4_nodone", 64'(done), 64'd0);
    end
    chk("t4_nwrites", 64'(wa_q.size()), 64'd24);
    if (wa_q.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        chk("t4_addr", 64'(wa_q[i]), 64'(i % 16));
        chk("t4_data", 64'(wd_q[i]), 64'(lw(6 + i / 8, i % 8)));
      end
    end
    chk("t4_frames", 64'(frames_captured), 64'd3);

    // Abort on the second write cycle.
    abort = 1'b1; cyc(); abort = 1'b0;
    lane_en = 14'h000F;
    do_arm();
    pulse_frame(9);
    cyc();
    chk("t5_w2_we", 64'(mem_we), 64'd1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_abort_we", 64'(mem_we), 64'd0);
    chk("t5_abort_busy", 64'(busy), 64'd0);
    chk("t5_abort_addr", 64'(mem_addr), 64'd1);

    // Abort and arm together: abort wins.
    arm = 1'b1; abort = 1'b1; cyc(); arm = 1'b0; abort = 1'b0;
    chk("t5_abort_arm", 64'(busy), 64'd0);

    // Reset mid-write with overflow set, colliding with arm and frame_valid.
    do_arm();
    pulse_frame(10);
    frame_valid = 1'b1; cyc();
    rst = 1'b1; arm = 1'b1;
    cyc();
    arm = 1'b0; frame_valid = 1'b0;
    chk_reset_outputs("t5_midrst");
    rst = 1'b0;
    cyc();

    // Arm with no lanes is ignored; frame_valid in IDLE is ignored.
    lane_en = 14'd0;
    do_arm();
    chk("t5_arm0_busy", 64'(busy), 64'd0);
    pulse_frame(11);
    chk("t5_idle_fv_we", 64'(mem_we), 64'd0);
    chk("t5_idle_fv_ovf", 64'(overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
